// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, parity engine FSM states,
// the default maximum frame width and the parity selection helper.
package uart_pkg;

   localparam int MAX_WIDTH = 9;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      READY = 2'd2
   } par_state_e;

   // Map the running XOR of the data bits onto the parity bit for a mode.
   function automatic logic par_calc(input logic [1:0] mode, input logic acc);
      logic res;
      case (mode)
         PAR_EVEN: res = acc;
         PAR_ODD:  res = ~acc;
         PAR_MARK: res = 1'b1;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/parity_engine_if.sv
// Handshake bundle between a UART serializer/deserializer and parity_engine.
//   master : frame control, serial data and received parity bit (drives);
//            status, parity result and error counter (observes)
//   slave  : the parity engine side
interface parity_engine_if #(
   parameter int LEN_W     = 4,
   parameter int ERR_CNT_W = 8
) ();

   logic                 start;
   logic [LEN_W-1:0]     data_len;
   logic [1:0]           par_mode;
   logic                 bit_valid;
   logic                 bit_in;
   logic                 chk_valid;
   logic                 chk_bit;
   logic                 busy;
   logic                 par_rdy;
   logic                 par_bit;
   logic                 done;
   logic                 par_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output start, data_len, par_mode, bit_valid, bit_in, chk_valid, chk_bit,
      input  busy, par_rdy, par_bit, done, par_err, err_cnt
   );

   modport slave (
      input  start, data_len, par_mode, bit_valid, bit_in, chk_valid, chk_bit,
      output busy, par_rdy, par_bit, done, par_err, err_cnt
   );

endinterface

// File: rtl/parity_sat_cnt.sv
// Saturating up-counter used for the parity mismatch count.
//   CLK : clock, rising edge
//   RST : asynchronous reset, active-low (clears the count)
//   inc : count one event this cycle
//   cnt : current count, holds at all-ones
module parity_sat_cnt #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/parity_engine.sv
// Serial parity generator/checker shared by the UART TX and RX paths.
// Accumulates parity over a runtime-length frame, presents the parity bit for
// the selected mode, and compares a received parity bit against it.
//   CLK : clock, rising edge
//   RST : asynchronous reset, active-low
//   bus : parity_engine_if slave (start/len/mode, serial bits, check bit in;
//         busy, par_rdy, par_bit, done, par_err, err_cnt out)
// Optional feature macro PARITY_ERR_CNT_EN: enables the saturating mismatch
// counter on err_cnt; without it err_cnt is constant zero.
//
// state | meaning
// IDLE  | no frame since reset
// ACCUM | shifting data bits into the accumulator
// READY | parity bit valid, received parity bits are checked
module parity_engine
   import uart_pkg::*;
#(
   parameter int MAX_WIDTH = uart_pkg::MAX_WIDTH,
   parameter int LEN_W     = $clog2(MAX_WIDTH + 1),
   parameter int ERR_CNT_W = 8
) (
   input  logic          CLK,
   input  logic          RST,
   parity_engine_if.slave bus
);

   par_state_e       state_q, state_d;
   logic             acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]       mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             par_rdy_q, par_rdy_d;
   logic             par_bit_q, par_bit_d;
   logic             done_q, done_d;
   logic             par_err_q, par_err_d;

   logic [LEN_W-1:0] len_in;
   logic [LEN_W-1:0] cnt_inc;
   logic             acc_nxt;

   // Zero-length frames become one bit; oversize frames clamp to MAX_WIDTH.
   always_comb begin
      len_in = bus.data_len;
      if (bus.data_len == '0) begin
         len_in = LEN_W'(1);
      end else if (bus.data_len > LEN_W'(MAX_WIDTH)) begin
         len_in = LEN_W'(MAX_WIDTH);
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      mode_d    = mode_q;
      busy_d    = busy_q;
      par_rdy_d = par_rdy_q;
      par_bit_d = par_bit_q;
      done_d    = 1'b0;
      par_err_d = par_err_q;
      cnt_inc   = cnt_q + LEN_W'(1);
      acc_nxt   = acc_q ^ bus.bit_in;

      if (bus.start) begin
         // A start aborts anything in flight; a coincident bit is bit 1 of
         // the new frame, which can already complete a one-bit frame.
         len_d     = len_in;
         mode_d    = bus.par_mode;
         par_rdy_d = 1'b0;
         par_err_d = 1'b0;
         busy_d    = 1'b1;
         state_d   = ACCUM;
         acc_d     = bus.bit_valid & bus.bit_in;
         cnt_d     = bus.bit_valid ? LEN_W'(1) : '0;
         if (bus.bit_valid && (len_in == LEN_W'(1))) begin
            state_d   = READY;
            busy_d    = 1'b0;
            par_rdy_d = 1'b1;
            done_d    = 1'b1;
            par_bit_d = par_calc(bus.par_mode, bus.bit_in);
         end
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (bus.bit_valid) begin
                  acc_d = acc_nxt;
                  cnt_d = cnt_inc;
                  if (cnt_inc == len_q) begin
                     state_d   = READY;
                     busy_d    = 1'b0;
                     par_rdy_d = 1'b1;
                     done_d    = 1'b1;
                     par_bit_d = par_calc(mode_q, acc_nxt);
                  end
               end
            end
            READY: begin
               if (bus.chk_valid && (bus.chk_bit != par_bit_q)) begin
                  par_err_d = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         acc_q     <= 1'b0;
         cnt_q     <= '0;
         len_q     <= '0;
         mode_q    <= PAR_EVEN;
         busy_q    <= 1'b0;
         par_rdy_q <= 1'b0;
         par_bit_q <= 1'b0;
         done_q    <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         busy_q    <= busy_d;
         par_rdy_q <= par_rdy_d;
         par_bit_q <= par_bit_d;
         done_q    <= done_d;
         par_err_q <= par_err_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.par_rdy = par_rdy_q;
   assign bus.par_bit = par_bit_q;
   assign bus.done    = done_q;
   assign bus.par_err = par_err_q;

`ifdef PARITY_ERR_CNT_EN
   // Same condition that sets par_err, but counted on every occurrence.
   logic mismatch;
   assign mismatch = !bus.start && (state_q == READY) && bus.chk_valid &&
                     (bus.chk_bit != par_bit_q);

   parity_sat_cnt #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (mismatch),
      .cnt (bus.err_cnt)
   );
`else
   assign bus.err_cnt = ERR_CNT_W'(0);
`endif

endmodule
